ddr3_seg_init: RTL

- Parametrised DDR3 preload sequencer that runs at power-up and writes NUM_SEGS independent address regions from one external init ROM.
- Sits between the init ROM and the DDR UI command/write-data wrapper. Raises init_done before the accelerator core is released.
- Splits each segment into write commands of at most MAX_BURST beats.
- A 2-entry prefetch buffer sustains 1 beat/cycle against the 1-cycle ROM latency.

---
 rtl/ddr3_seg_init_if.sv | 35 +++
 rtl/ddr3_seg_init.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_seg_init_if.sv
// Signal bundle between the DDR3 preload sequencer, its init ROM and the DDR UI write wrapper.
// master = sequencer side, slave = ROM/controller side.
interface ddr3_seg_init_if #(
  parameter int unsigned UI_WIDTH   = 512,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned ROM_AW     = 12
);
  logic                  ddr_start;
  logic                  ddr_rdy;
  logic                  ddr_wdf_data_rdy;
  logic                  ddr_wr_finish;
  logic [ROM_AW-1:0]     rom_addr;
  logic [UI_WIDTH-1:0]   rom_data;
  logic [2:0]            ddr_cmd;
  logic                  ddr_cmd_valid;
  logic [ADDR_WIDTH-1:0] ddr_base_addr;
  logic [9:0]            ddr_size;
  logic [UI_WIDTH-1:0]   ddr_wdf_data;
  logic                  ddr_wdf_data_valid;
  logic [3:0]            seg_idx;
  logic                  busy;
  logic                  init_done;

  modport master (
    input  ddr_start, ddr_rdy, ddr_wdf_data_rdy, ddr_wr_finish, rom_data,
    output rom_addr, ddr_cmd, ddr_cmd_valid, ddr_base_addr, ddr_size,
           ddr_wdf_data, ddr_wdf_data_valid, seg_idx, busy, init_done
  );

  modport slave (
    output ddr_start, ddr_rdy, ddr_wdf_data_rdy, ddr_wr_finish, rom_data,
    input  rom_addr, ddr_cmd, ddr_cmd_valid, ddr_base_addr, ddr_size,
           ddr_wdf_data, ddr_wdf_data_valid, seg_idx, busy, init_done
  );
endinterface

// File: rtl/ddr3_seg_init.sv
// Power-up DDR3 preload sequencer: copies NUM_SEGS regions from a 1-cycle-latency init ROM into DDR.
// Optional macro DDR3_SEG_INIT_RESTART_EN: a start edge in DONE reruns the whole sequence.
module ddr3_seg_init #(
  parameter int unsigned DDR_WIDTH  = 64,
  parameter int unsigned UI_WIDTH   = DDR_WIDTH * 8,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned NUM_SEGS   = 4,
  parameter logic [NUM_SEGS*ADDR_WIDTH-1:0] SEG_BASE = '0,
  parameter logic [NUM_SEGS*16-1:0]         SEG_SIZE = '0,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned ADDR_STEP  = 8,
  parameter int unsigned ROM_AW     = 12
) (
  input  logic            ui_clk,
  input  logic            ui_rst,
  ddr3_seg_init_if.master bus
);

  typedef enum logic [2:0] {IDLE, SEG, CMD, DATA, FIN, DONE} state_t;

  localparam int unsigned SEG_W = 5;
  localparam int unsigned CNT_W = 10;

  function automatic int unsigned total_beats();
    int unsigned t;
    t = 0;
    for (int k = 0; k < int'(NUM_SEGS); k++) t += 32'(SEG_SIZE[k*16 +: 16]);
    return t;
  endfunction

  // Last ROM address in use; rom_addr parks here after the final read.
  localparam logic [ROM_AW-1:0] ROM_LAST = ROM_AW'(total_beats() - 32'd1);

  function automatic logic [15:0] size_of(input logic [SEG_W-1:0] k);
    if (32'(k) < NUM_SEGS) return SEG_SIZE[32'(k)*16 +: 16];
    return 16'd0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [SEG_W-1:0] k);
    if (32'(k) < NUM_SEGS) return SEG_BASE[32'(k)*ADDR_WIDTH +: ADDR_WIDTH];
    return '0;
  endfunction

  state_t                state, state_n;
  logic                  start_q;
  logic [SEG_W-1:0]      seg_cnt, seg_n;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_n;
  logic [15:0]           remaining, rem_n;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic [CNT_W-1:0]      size_q, size_n;
  logic [CNT_W-1:0]      issued, issued_n;
  logic [CNT_W-1:0]      sent, sent_n;
  logic [1:0]            fifo_cnt, cnt_n;
  logic                  rd_pend;
  logic                  fin_seen, fin_n;
  logic                  cmd_valid_q, cmd_valid_n;
  logic                  valid_q, valid_n;
  logic [2:0]            cmd_q, cmd_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic [UI_WIDTH-1:0]   slot0, slot1;

  logic                  start_edge;
  logic                  pop;
  logic                  rd_en;
  logic [CNT_W-1:0]      chunk_c;
  logic [CNT_W-1:0]      chunk_eff;
  logic [2:0]            occ;

  assign start_edge = bus.ddr_start & ~start_q;

  // Next-state, counters, prefetch flow control and registered-output next values.
  always_comb begin
    state_n     = state;
    seg_n       = seg_cnt;
    rom_addr_n  = rom_addr_q;
    rem_n       = remaining;
    cur_n       = cur_addr;
    base_n      = base_q;
    size_n      = size_q;
    issued_n    = issued;
    sent_n      = sent;
    fin_n       = fin_seen;
    cmd_valid_n = 1'b0;
    done_n      = done_q;
    rd_en       = 1'b0;

    pop       = valid_q & bus.ddr_wdf_data_rdy;
    chunk_c   = (remaining < 16'(MAX_BURST)) ? remaining[CNT_W-1:0] : CNT_W'(MAX_BURST);
    chunk_eff = (state == CMD) ? chunk_c : size_q;
    // Buffered plus in-flight beats; a read is only issued when a slot will be free.
    occ       = 3'(fifo_cnt) + 3'(rd_pend);

    if ((state == CMD || state == DATA) && issued < chunk_eff && occ < (3'd2 + 3'(pop)))
      rd_en = 1'b1;
    if (rd_en) begin
      issued_n = issued + CNT_W'(1);
      if (rom_addr_q != ROM_LAST) rom_addr_n = rom_addr_q + ROM_AW'(1);
    end
    cnt_n = fifo_cnt + 2'(rd_pend) - 2'(pop);
    if (pop) sent_n = sent + CNT_W'(1);
    if (state == DATA && bus.ddr_wr_finish) fin_n = 1'b1;

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_n    = SEG;
          seg_n      = '0;
          rom_addr_n = '0;
        end
      end
      SEG: begin
        if (seg_cnt == SEG_W'(NUM_SEGS)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (size_of(seg_cnt) == 16'd0) begin
          seg_n = seg_cnt + SEG_W'(1);
        end else begin
          rem_n    = size_of(seg_cnt);
          cur_n    = base_of(seg_cnt);
          issued_n = '0;
          sent_n   = '0;
          state_n  = CMD;
        end
      end
      CMD: begin
        size_n = chunk_c;
        base_n = cur_addr;
        if (bus.ddr_rdy) begin
          cmd_valid_n = 1'b1;
          state_n     = DATA;
        end
      end
      DATA: begin
        if (pop && sent == size_q - CNT_W'(1)) state_n = FIN;
      end
      FIN: begin
        if (bus.ddr_wr_finish || fin_seen) begin
          fin_n    = 1'b0;
          rem_n    = remaining - 16'(size_q);
          cur_n    = cur_addr + ADDR_WIDTH'(32'(size_q) * ADDR_STEP);
          issued_n = '0;
          sent_n   = '0;
          if (rem_n != 16'd0) begin
            state_n = CMD;
          end else begin
            seg_n   = seg_cnt + SEG_W'(1);
            state_n = SEG;
          end
        end
      end
      DONE: begin
`ifdef DDR3_SEG_INIT_RESTART_EN
        if (start_edge) begin
          state_n    = SEG;
          seg_n      = '0;
          rom_addr_n = '0;
          done_n     = 1'b0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n == SEG) || (state_n == CMD) || (state_n == DATA) || (state_n == FIN);
    cmd_n   = ((state_n == CMD) || (state_n == DATA) || (state_n == FIN)) ? 3'd0 : 3'd2;
    valid_n = (state_n == DATA) && (cnt_n != 2'd0);
  end

  // Control and output registers.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      seg_cnt     <= '0;
      rom_addr_q  <= '0;
      remaining   <= '0;
      cur_addr    <= '0;
      base_q      <= '0;
      size_q      <= '0;
      issued      <= '0;
      sent        <= '0;
      fifo_cnt    <= '0;
      rd_pend     <= 1'b0;
      fin_seen    <= 1'b0;
      cmd_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      cmd_q       <= 3'd2;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      start_q     <= bus.ddr_start;
      seg_cnt     <= seg_n;
      rom_addr_q  <= rom_addr_n;
      remaining   <= rem_n;
      cur_addr    <= cur_n;
      base_q      <= base_n;
      size_q      <= size_n;
      issued      <= issued_n;
      sent        <= sent_n;
      fifo_cnt    <= cnt_n;
      rd_pend     <= rd_en;
      fin_seen    <= fin_n;
      cmd_valid_q <= cmd_valid_n;
      valid_q     <= valid_n;
      cmd_q       <= cmd_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
    end
  end

  // Two-slot prefetch buffer; slot0 is the presented write beat.
  always_ff @(posedge ui_clk) begin
    if (pop && fifo_cnt == 2'd2) slot0 <= slot1;
    if (rd_pend) begin
      if (fifo_cnt - 2'(pop) == 2'd0) slot0 <= bus.rom_data;
      else                            slot1 <= bus.rom_data;
    end
  end

  assign bus.rom_addr           = rom_addr_q;
  assign bus.ddr_cmd            = cmd_q;
  assign bus.ddr_cmd_valid      = cmd_valid_q;
  assign bus.ddr_base_addr      = base_q;
  assign bus.ddr_size           = size_q;
  assign bus.ddr_wdf_data       = slot0;
  assign bus.ddr_wdf_data_valid = valid_q;
  assign bus.seg_idx            = seg_cnt[3:0];
  assign bus.busy               = busy_q;
  assign bus.init_done          = done_q;

endmodule
